// File: rtl/cplx_serial_combine.sv
// Bit-serial combiner for a complex multiply: forms re = ac - bd and
// im = ad + bc from four unsigned partial products, one bit per cycle,
// LSB first, with a valid/ready handshake on both sides.
module cplx_serial_combine #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] ac,
    input  logic [W-1:0] bd,
    input  logic [W-1:0] ad,
    input  logic [W-1:0] bc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   re,
    output logic [W:0]   im,
    output logic         busy
);

    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [W-1:0]  r_ac;
    logic [W-1:0]  r_bd;
    logic [W-1:0]  r_ad;
    logic [W-1:0]  r_bc;
    logic          r_bo;
    logic          r_cy;
    logic [CW-1:0] r_cnt;
    logic [W:0]    r_re;
    logic [W:0]    r_im;

    logic          w_accept;
    logic          w_last;
    logic          w_d;
    logic          w_bo_nxt;
    logic          w_s;
    logic          w_cy_nxt;

    // Handshake qualifiers and one full-subtractor / full-adder step on bit 0
    // of the operand shift registers.
    always_comb begin
        w_accept = (r_state == S_IDLE) && in_valid;
        w_last   = (r_cnt == LAST);
        w_d      = r_ac[0] ^ r_bd[0] ^ r_bo;
        w_bo_nxt = (~r_ac[0] & r_bo) | (~r_ac[0] & r_bd[0]) | (r_bd[0] & r_bo);
        w_s      = r_ad[0] ^ r_bc[0] ^ r_cy;
        w_cy_nxt = (r_ad[0] & r_bc[0]) | (r_ad[0] & r_cy) | (r_bc[0] & r_cy);
    end

    // State register; reset wins over acceptance and handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, W serial cycles in RUN, hold in DONE
    // until the consumer takes the result.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    // Serial datapath: load operands on accept, then shift one result bit
    // per RUN cycle into the top of re/im so bit 0 lands at position 0
    // after W shifts. The final borrow/carry fills the extra MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ac  <= '0;
            r_bd  <= '0;
            r_ad  <= '0;
            r_bc  <= '0;
            r_bo  <= 1'b0;
            r_cy  <= 1'b0;
            r_cnt <= '0;
            r_re  <= '0;
            r_im  <= '0;
        end else if (w_accept) begin
            r_ac  <= ac;
            r_bd  <= bd;
            r_ad  <= ad;
            r_bc  <= bc;
            r_bo  <= 1'b0;
            r_cy  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_ac  <= r_ac >> 1;
            r_bd  <= r_bd >> 1;
            r_ad  <= r_ad >> 1;
            r_bc  <= r_bc >> 1;
            r_bo  <= w_bo_nxt;
            r_cy  <= w_cy_nxt;
            r_cnt <= r_cnt + CW'(1);
            r_re  <= {(w_last ? w_bo_nxt : r_re[W]), w_d, r_re[W-1:1]};
            r_im  <= {(w_last ? w_cy_nxt : r_im[W]), w_s, r_im[W-1:1]};
        end
    end

    // Handshake outputs decode directly from state, so there is never a
    // same-cycle handoff between out_valid and in_ready.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        re        = r_re;
        im        = r_im;
    end

endmodule

// File: tb/tb_cplx_serial_combine.sv
// Self-checking bench for cplx_serial_combine: directed vectors, random
// transactions against an arithmetic reference, backpressure, input
// ignoring during RUN and reset in RUN/DONE.
module tb_cplx_serial_combine;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ac, bd, ad, bc;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   re, im;
    logic         busy;

    int n_pass;
    int n_total;

    cplx_serial_combine #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ac(ac), .bd(bd), .ad(ad), .bc(bc),
        .out_valid(out_valid), .out_ready(out_ready),
        .re(re), .im(im), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain (W+1)-bit arithmetic.
    function automatic logic [W:0] model_re(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] x, y;
        x = {1'b0, a};
        y = {1'b0, b};
        return x - y;
    endfunction

    function automatic logic [W:0] model_im(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] x, y;
        x = {1'b0, a};
        y = {1'b0, b};
        return x + y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one set, accept it and wait (bounded) for out_valid.
    // lat = number of edges after the accepting edge, or -1 on timeout.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d,
                           output int lat, output logic [W:0] ore, output logic [W:0] oim);
        ac = a; bd = b; ad = c; bc = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 3 * W; i++) begin
            step();
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        ore = re;
        oim = im;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ac = '0; bd = '0; ad = '0; bc = '0;
        step(); step();
        rst = 1'b0;
        n_total++;
        if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_flags got=%b want=100", {in_ready, out_valid, busy});
        else n_pass++;
        n_total++;
        if ({re, im} !== '0) $display("FAIL reset_data got re=%h im=%h want 0", re, im);
        else n_pass++;
        // Idle with in_valid=0 must leave everything unchanged.
        ac = 16'h1234; bd = 16'h5678;
        for (int i = 0; i < 4; i++) step();
        n_total++;
        if ({in_ready, busy, re, im} !== {1'b1, 1'b0, {(2*W+2){1'b0}}})
            $display("FAIL idle_hold got rdy=%b busy=%b re=%h im=%h", in_ready, busy, re, im);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[3][4];
        logic [W:0]   ere[3], eim[3];
        int lat;
        logic [W:0] ore, oim;
        va[0] = '{16'h0005, 16'h0003, 16'h0002, 16'h0004}; ere[0] = 17'h00002; eim[0] = 17'h00006;
        va[1] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0001}; ere[1] = 17'h1FFFF; eim[1] = 17'h10000;
        va[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; ere[2] = 17'h00000; eim[2] = 17'h1FFFE;
        for (int k = 0; k < 3; k++) begin
            run_txn(va[k][0], va[k][1], va[k][2], va[k][3], lat, ore, oim);
            n_total++;
            if (lat !== W) $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, W);
            else n_pass++;
            n_total++;
            if (ore !== ere[k] || oim !== eim[k])
                $display("FAIL dir%0d_result got re=%h im=%h want re=%h im=%h", k, ore, oim, ere[k], eim[k]);
            else n_pass++;
            n_total++;
            if ({in_ready, busy} !== 2'b01) $display("FAIL dir%0d_done_flags got rdy=%b busy=%b want 0/1", k, in_ready, busy);
            else n_pass++;
            handoff();
            n_total++;
            if ({out_valid, in_ready, busy} !== 3'b010 || re !== ere[k] || im !== eim[k])
                $display("FAIL dir%0d_after_handoff got ov=%b rdy=%b busy=%b re=%h im=%h", k, out_valid, in_ready, busy, re, im);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W:0] ore, oim, ere, eim;
        ere = model_re(16'h0100, 16'h0200);
        eim = model_im(16'h8000, 16'h8001);
        run_txn(16'h0100, 16'h0200, 16'h8000, 16'h8001, lat, ore, oim);
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || re !== ere || im !== eim)
                $display("FAIL bp_hold%0d got ov=%b rdy=%b re=%h im=%h want 1/0 re=%h im=%h", i, out_valid, in_ready, re, im, ere, eim);
            else n_pass++;
        end
        handoff();
        n_total++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release got ov=%b rdy=%b want 0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_ignore_run();
        int lat;
        logic [W:0] ere, eim;
        bit ok_rdy;
        ere = model_re(16'h4321, 16'h1234);
        eim = model_im(16'h0F0F, 16'hF0F0);
        ac = 16'h4321; bd = 16'h1234; ad = 16'h0F0F; bc = 16'hF0F0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        // Bit 5 is processed on the next edge: hit the inputs with new data.
        ac = 16'hAAAA; bd = 16'h5555; ad = 16'hFFFF; bc = 16'hFFFF;
        in_valid = 1'b1;
        lat = -1;
        ok_rdy = 1'b1;
        for (int i = 6; i <= 3 * W; i++) begin
            step();
            if (in_ready !== 1'b0) ok_rdy = 1'b0;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        in_valid = 1'b0;
        n_total++;
        if (lat !== W || !ok_rdy) $display("FAIL ign_latency got=%0d rdy_ok=%0d want=%0d/1", lat, ok_rdy, W);
        else n_pass++;
        n_total++;
        if (re !== ere || im !== eim) $display("FAIL ign_result got re=%h im=%h want re=%h im=%h", re, im, ere, eim);
        else n_pass++;
        handoff();
        step();
        n_total++;
        if ({busy, out_valid, in_ready} !== 3'b001) $display("FAIL ign_no_second got busy=%b ov=%b rdy=%b want 0/0/1", busy, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [W:0] ore, oim;
        bit seen;
        ac = 16'h7777; bd = 16'h1111; ad = 16'h2222; bc = 16'h3333;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if ({in_ready, out_valid, busy} !== 3'b100 || re !== '0 || im !== '0)
            $display("FAIL rstrun_state got rdy=%b ov=%b busy=%b re=%h im=%h", in_ready, out_valid, busy, re, im);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL rstrun_no_pulse got out_valid pulse want none");
        else n_pass++;
        run_txn(16'h0005, 16'h0003, 16'h0002, 16'h0004, lat, ore, oim);
        n_total++;
        if (lat !== W || ore !== 17'h00002 || oim !== 17'h00006)
            $display("FAIL rstrun_after got lat=%0d re=%h im=%h want %0d 00002 00006", lat, ore, oim, W);
        else n_pass++;
        // Reset in DONE takes priority over a simultaneous handoff.
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        n_total++;
        if ({in_ready, out_valid, busy} !== 3'b100 || re !== '0 || im !== '0)
            $display("FAIL rstdone_state got rdy=%b ov=%b busy=%b re=%h im=%h", in_ready, out_valid, busy, re, im);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W:0] ore, oim;
        logic [W-1:0] a, b, c, d;
        for (int k = 0; k < 20; k++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
            if (k == 0) begin a = 16'h0000; b = 16'hFFFF; end
            if (k == 1) begin c = 16'h8000; d = 16'h8000; end
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL b2b%0d_ready got=%b want=1", k, in_ready);
            else n_pass++;
            run_txn(a, b, c, d, lat, ore, oim);
            n_total++;
            if (lat !== W || ore !== model_re(a, b) || oim !== model_im(c, d))
                $display("FAIL b2b%0d got lat=%0d re=%h im=%h want lat=%0d re=%h im=%h",
                         k, lat, ore, oim, W, model_re(a, b), model_im(c, d));
            else n_pass++;
            handoff();
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_ignore_run();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
